// File: rtl/writeback_arbiter.sv
// Merges ALU and LSU results onto one register-file write port: ALU 1 cycle, LSU >= 2 cycles via a DEPTH-entry FIFO.
// ALU is never stalled and has priority; LSU is throttled only by lsu_ready (= FIFO not full).
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_valid,
  input  logic [4:0]         alu_rd,
  input  logic signed [31:0] alu_data,
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  logic [4:0]         lsu_rd,
  input  logic signed [31:0] lsu_data,
  output logic               reg_wr,
  output logic [4:0]         waddr,
  output logic signed [31:0] wdata,
  input  logic [4:0]         raddr1,
  input  logic [4:0]         raddr2,
  output logic               fwd_hit1,
  output logic               fwd_hit2,
  output logic signed [31:0] fwd_data1,
  output logic signed [31:0] fwd_data2,
  output logic               idle
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic               hit;
    logic signed [31:0] data;
  } fwd_t;

  logic               fifo_live [DEPTH];
  logic [4:0]         fifo_rd   [DEPTH];
  logic signed [31:0] fifo_data [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [PW:0]        count;

  logic full;
  logic alu_wr;
  logic store;
  logic pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign lsu_ready = !reset && !full;
  assign alu_wr    = alu_valid && (alu_rd != 5'd0);
  // x0 results are handshaken but never occupy a slot.
  assign store     = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  assign pop       = !alu_wr && (count != '0);
  assign idle      = reset || ((count == '0) && !reg_wr);

  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      reg_wr <= 1'b0;
      waddr  <= 5'd0;
      wdata  <= 32'sd0;
      for (int i = 0; i < DEPTH; i++) fifo_live[i] <= 1'b0;
    end else begin
      // Killing free slots is harmless; a same-cycle push below overrides its own slot.
      if (alu_wr) begin
        for (int i = 0; i < DEPTH; i++)
          if (fifo_rd[i] == alu_rd) fifo_live[i] <= 1'b0;
      end
      if (store) begin
        fifo_live[tail] <= 1'b1;
        fifo_rd[tail]   <= lsu_rd;
        fifo_data[tail] <= lsu_data;
        tail            <= tail + PW'(1);
      end
      if (alu_wr) begin
        reg_wr <= 1'b1;
        waddr  <= alu_rd;
        wdata  <= alu_data;
      end else if (pop) begin
        reg_wr <= fifo_live[head];
        waddr  <= fifo_rd[head];
        wdata  <= fifo_data[head];
        head   <= head + PW'(1);
      end else begin
        reg_wr <= 1'b0;
      end
      case ({store, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest live match is the one left standing.
  function automatic fwd_t lookup(input logic [4:0] ra);
    fwd_t          r;
    logic [PW-1:0] idx;
    r = '0;
    if (ra != 5'd0) begin
      if (reg_wr && (waddr == ra)) begin
        r.hit  = 1'b1;
        r.data = wdata;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PW'(k);
        if (((PW+1)'(k) < count) && fifo_live[idx] && (fifo_rd[idx] == ra)) begin
          r.hit  = 1'b1;
          r.data = fifo_data[idx];
        end
      end
    end
    return r;
  endfunction

  fwd_t fwd1;
  fwd_t fwd2;

  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    if (!reset) begin
      fwd1 = lookup(raddr1);
      fwd2 = lookup(raddr2);
    end
  end

  assign fwd_hit1  = fwd1.hit;
  assign fwd_data1 = fwd1.data;
  assign fwd_hit2  = fwd2.hit;
  assign fwd_data2 = fwd2.data;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scenarios plus random traffic, checked against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic        idle;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .idle(idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending LSU results in arrival order, plus the committed-next write.
  typedef struct {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_vld;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          model_ok = 0;

  function automatic logic [32:0] m_fwd(input logic [4:0] ra);
    if (reset || ra == 5'd0) return 33'd0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].live && q[i].rd == ra) return {1'b1, q[i].data};
    if (m_vld && m_rd == ra) return {1'b1, m_data};
    return 33'd0;
  endfunction

  task automatic check_model();
    logic [32:0] f1, f2;
    f1 = m_fwd(raddr1);
    f2 = m_fwd(raddr2);
    chk("reg_wr", reg_wr, m_vld);
    if (m_vld) begin
      chk("waddr", waddr, m_rd);
      chk("wdata", wdata, m_data);
    end
    chk("lsu_ready", lsu_ready, !reset && q.size() < DEPTH);
    chk("idle", idle, reset || (q.size() == 0 && !m_vld));
    chk("fwd_hit1", fwd_hit1, f1[32]);
    chk("fwd_data1", fwd_data1, f1[31:0]);
    chk("fwd_hit2", fwd_hit2, f2[32]);
    chk("fwd_data2", fwd_data2, f2[31:0]);
  endtask

  task automatic model_update();
    bit   aw, rdy;
    ent_t e;
    if (reset) begin
      q.delete();
      m_vld = 0; m_rd = 0; m_data = 0;
      model_ok = 1;
    end else begin
      aw  = alu_valid && alu_rd != 5'd0;
      rdy = q.size() < DEPTH;
      if (aw) begin
        foreach (q[i]) if (q[i].rd == alu_rd) q[i].live = 1'b0;
        m_vld = 1; m_rd = alu_rd; m_data = alu_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_vld = e.live; m_rd = e.rd; m_data = e.data;
      end else begin
        m_vld = 0;
      end
      if (lsu_valid && rdy && lsu_rd != 5'd0) begin
        e.live = 1'b1; e.rd = lsu_rd; e.data = lsu_data;
        q.push_back(e);
      end
    end
  endtask

  // One clock: drive inputs after the edge, compare against the model, then advance both.
  task automatic step(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic [4:0] r1, input logic [4:0] r2);
    #1;
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; raddr1 = r1; raddr2 = r2;
    #1;
    if (model_ok) check_model();
    @(posedge clk);
    model_update();
  endtask

  task automatic nop(input logic [4:0] r1);
    step(0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  initial begin
    bit          av, lv, rst;
    logic [4:0]  ard, lrd, r1, r2;
    logic [31:0] ad, ld;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 5, 0);
    #2;
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ready", lsu_ready, 0);
    chk("rst_fwd_hit", fwd_hit1, 0);
    nop(0);
    #2;
    chk("rel_ready", lsu_ready, 1);

    // ALU pass-through
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    #2;
    chk("pt_wr", reg_wr, 1);
    chk("pt_addr", waddr, 5);
    chk("pt_data", wdata, 32'hDEADBEEF);
    nop(0);
    #2;
    chk("pt_wr_after", reg_wr, 0);
    chk("pt_idle", idle, 1);

    // Fill and back-pressure while the ALU hogs the port
    for (int i = 0; i < 4; i++) step(0, 1, 1, 32'h1000 + i, 1, 5'(10 + i), 32'h100 + i, 0, 0);
    #2;
    chk("full_ready", lsu_ready, 0);
    step(0, 1, 1, 32'h2000, 1, 14, 32'h1FF, 14, 0);
    #2;
    chk("full_no_take", lsu_ready, 0);
    chk("full_no_fwd14", fwd_hit1, 0);
    for (int i = 0; i < 4; i++) begin
      nop(0);
      #2;
      chk("drain_wr", reg_wr, 1);
      chk("drain_addr", waddr, 5'(10 + i));
      chk("drain_data", wdata, 32'h100 + i);
      if (i == 0) chk("drain_ready", lsu_ready, 1);
    end
    nop(0);

    // Kill: queued LSU rd7 overtaken by ALU rd7
    step(0, 1, 1, 32'h5, 1, 7, 32'h11, 0, 0);
    step(0, 1, 7, 32'h22, 0, 0, 0, 7, 0);
    #2;
    chk("kill_addr", waddr, 7);
    chk("kill_data", wdata, 32'h22);
    chk("kill_fwd_hit", fwd_hit1, 1);
    chk("kill_fwd_data", fwd_data1, 32'h22);
    nop(7);
    #2;
    chk("kill_bubble", reg_wr, 0);
    nop(0);
    #2;
    chk("kill_idle", idle, 1);

    // Same-cycle ALU and LSU to rd3
    step(0, 1, 3, 32'hA, 1, 3, 32'hB, 3, 0);
    #2;
    chk("same_alu_data", wdata, 32'hA);
    chk("same_fwd_data", fwd_data1, 32'hB);
    nop(3);
    #2;
    chk("same_lsu_wr", reg_wr, 1);
    chk("same_lsu_data", wdata, 32'hB);
    nop(0);

    // x0 writes are dropped
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'h77, 1, 0, 32'h88, 0, 0);
      #2;
      chk("x0_wr", reg_wr, 0);
      chk("x0_idle", idle, 1);
      chk("x0_fwd", fwd_hit1, 0);
    end

    // Reset with entries queued
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h9, 1, 5'(20 + i), 32'h300 + i, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 20, 21);
    #2;
    chk("mid_rst_wr", reg_wr, 0);
    chk("mid_rst_idle", idle, 1);
    for (int i = 0; i < 4; i++) begin
      nop(20);
      #2;
      chk("post_rst_wr", reg_wr, 0);
      chk("post_rst_ready", lsu_ready, 1);
    end

    // Random traffic in alternating ALU-heavy / LSU-heavy phases
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      av  = ((i / 150) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      lv  = $urandom_range(0, 1);
      ard = 5'($urandom_range(0, 7));
      lrd = 5'($urandom_range(0, 7));
      r1  = 5'($urandom_range(0, 7));
      r2  = 5'($urandom_range(0, 7));
      ad  = $urandom;
      ld  = $urandom;
      step(rst, av, ard, ad, lv, lrd, ld, r1, r2);
    end
    nop(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
